// File: rtl/conv_window_req_pkg.sv
// Shared types and helpers for the convolution window read-request generator.
package conv_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } state_e;

  // Row/compare counters carry one extra bit so row_start + K never overflows.
  function automatic int cmp_width(input int dim_width);
    return dim_width + 1;
  endfunction

  function automatic logic cfg_legal(input int unsigned w, input int unsigned h,
                                     input int unsigned k, input int unsigned s);
    return (w != 0) && (k != 0) && (s != 0) && (k <= h);
  endfunction

endpackage

// File: rtl/conv_window_req_nest_cnt.sv
// Loop counter with load, enable and a terminal-count flag that fires when the
// next step would move past the terminal value.
module nest_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_next;

  assign cnt_next = {1'b0, cnt_q} + {1'b0, i_step};
  assign o_tc     = cnt_next > {1'b0, i_term};
  assign o_cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en) begin
      cnt_d = o_tc ? '0 : cnt_next[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv_window_req.sv
// Walks K-row window bands of a row-major feature map and issues one BRAM
// read per cycle, advancing bands by a vertical stride.
module conv_window_req
  import conv_req_pkg::*;
#(
  parameter int ADDR_WIDTH        = 32,
  parameter int DIM_WIDTH         = 8,
  parameter int KERNEL_SIZE_WIDTH = 3,
  parameter int STRIDE_WIDTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_stall,
  input  logic [ADDR_WIDTH-1:0]        i_conf_base,
  input  logic [DIM_WIDTH-1:0]         i_conf_width,
  input  logic [DIM_WIDTH-1:0]         i_conf_height,
  input  logic [KERNEL_SIZE_WIDTH-1:0] i_conf_kernel,
  input  logic [STRIDE_WIDTH-1:0]      i_conf_stride,
  output logic [ADDR_WIDTH-1:0]        o_addr,
  output logic                         o_rden,
  output logic [KERNEL_SIZE_WIDTH-1:0] o_ky,
  output logic                         o_row_last,
  output logic                         o_band_last,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int CW = cmp_width(DIM_WIDTH);

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]        row_addr_q, row_addr_d;
  logic [ADDR_WIDTH-1:0]        band_addr_q, band_addr_d;
  logic [ADDR_WIDTH-1:0]        band_step_q, band_step_d;
  logic [DIM_WIDTH-1:0]         w_q, w_d, h_q, h_d;
  logic [KERNEL_SIZE_WIDTH-1:0] k_q, k_d;
  logic [STRIDE_WIDTH-1:0]      s_q, s_d;
  logic                         err_q, err_d;

  logic [ADDR_WIDTH-1:0]        w_ext, step_sum;
  logic                         run, rden, cnt_load, legal;
  logic                         x_tc, ky_tc, band_tc;
  logic [DIM_WIDTH-1:0]         x_cnt, x_term;
  logic [KERNEL_SIZE_WIDTH-1:0] ky_cnt, ky_term;
  logic [CW-1:0]                row_start, band_term;

  assign w_ext     = ADDR_WIDTH'(w_q);
  assign x_term    = w_q - DIM_WIDTH'(1);
  assign ky_term   = k_q - KERNEL_SIZE_WIDTH'(1);
  // Last band once row_start + S would exceed H - K.
  assign band_term = CW'(h_q) - CW'(k_q);
  assign legal     = cfg_legal(32'(w_q), 32'(h_q), 32'(k_q), 32'(s_q));
  assign run       = (state_q == ST_RUN);
  assign rden      = run & ~i_stall & ~i_abort;
  assign cnt_load  = (state_q == ST_SETUP);

  // S*W by shift-and-add over the stride bits.
  always_comb begin
    step_sum = '0;
    for (int i = 0; i < STRIDE_WIDTH; i++) begin
      if (s_q[i]) step_sum = step_sum + (w_ext << i);
    end
  end

  nest_cnt #(.WIDTH(DIM_WIDTH)) u_x_cnt (
    .clk(clk), .rst(rst), .i_load(cnt_load), .i_load_val('0),
    .i_en(rden), .i_step(DIM_WIDTH'(1)), .i_term(x_term),
    .o_cnt(x_cnt), .o_tc(x_tc)
  );

  nest_cnt #(.WIDTH(KERNEL_SIZE_WIDTH)) u_ky_cnt (
    .clk(clk), .rst(rst), .i_load(cnt_load), .i_load_val('0),
    .i_en(rden & x_tc), .i_step(KERNEL_SIZE_WIDTH'(1)), .i_term(ky_term),
    .o_cnt(ky_cnt), .o_tc(ky_tc)
  );

  nest_cnt #(.WIDTH(CW)) u_band_cnt (
    .clk(clk), .rst(rst), .i_load(cnt_load), .i_load_val('0),
    .i_en(rden & x_tc & ky_tc), .i_step(CW'(s_q)), .i_term(band_term),
    .o_cnt(row_start), .o_tc(band_tc)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    row_addr_d  = row_addr_q;
    band_addr_d = band_addr_q;
    band_step_d = band_step_q;
    w_d         = w_q;
    h_d         = h_q;
    k_d         = k_q;
    s_d         = s_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SETUP;
          base_d  = i_conf_base;
          w_d     = i_conf_width;
          h_d     = i_conf_height;
          k_d     = i_conf_kernel;
          s_d     = i_conf_stride;
        end
      end
      ST_SETUP: begin
        band_step_d = step_sum;
        err_d       = ~legal;
        addr_d      = base_q;
        row_addr_d  = base_q;
        band_addr_d = base_q;
        state_d     = legal ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (rden) begin
          if (!x_tc) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end else if (!ky_tc) begin
            row_addr_d = row_addr_q + w_ext;
            addr_d     = row_addr_q + w_ext;
          end else begin
            band_addr_d = band_addr_q + band_step_q;
            row_addr_d  = band_addr_q + band_step_q;
            addr_d      = band_addr_q + band_step_q;
            if (band_tc) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      row_addr_q  <= '0;
      band_addr_q <= '0;
      band_step_q <= '0;
      w_q         <= '0;
      h_q         <= '0;
      k_q         <= '0;
      s_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      row_addr_q  <= row_addr_d;
      band_addr_q <= band_addr_d;
      band_step_q <= band_step_d;
      w_q         <= w_d;
      h_q         <= h_d;
      k_q         <= k_d;
      s_q         <= s_d;
      err_q       <= err_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_rden      = rden;
  assign o_ky        = ky_cnt;
  assign o_row_last  = run & x_tc;
  assign o_band_last = run & x_tc & ky_tc;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE) & ~err_q;
  assign o_err       = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_conv_window_req.sv
// Directed-vector bench for conv_window_req: per-read address/flag checks,
// pass timing, illegal configs, stall, abort, restart and mid-pass reset.
module tb_conv_window_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_stall;
  logic [31:0] i_conf_base;
  logic [7:0]  i_conf_width, i_conf_height;
  logic [2:0]  i_conf_kernel;
  logic [1:0]  i_conf_stride;
  logic [31:0] o_addr;
  logic        o_rden;
  logic [2:0]  o_ky;
  logic        o_row_last, o_band_last, o_busy, o_done, o_err;

  always #5 clk = ~clk;

  conv_window_req #(
    .ADDR_WIDTH(32), .DIM_WIDTH(8), .KERNEL_SIZE_WIDTH(3), .STRIDE_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_stall(i_stall),
    .i_conf_base(i_conf_base), .i_conf_width(i_conf_width),
    .i_conf_height(i_conf_height), .i_conf_kernel(i_conf_kernel),
    .i_conf_stride(i_conf_stride), .o_addr(o_addr), .o_rden(o_rden), .o_ky(o_ky),
    .o_row_last(o_row_last), .o_band_last(o_band_last), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    int          w, h, k, s;
    logic [31:0] base;
    int          exp_reads;
    logic [31:0] exp_last;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  ky;
    logic        rl;
    logic        bl;
  } rd_t;

  vec_t vecs[11];
  rd_t  expq[$];
  int   errors = 0;
  int   checks = 0;

  int          n_reads, first_cyc, last_cyc, done_cnt, err_cnt, done_cyc, err_cyc, idle_cyc;
  logic [31:0] last_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, 64'(o_addr), 64'h0);
    chk({tag, "_ky"}, 64'(o_ky), 64'h0);
    chk({tag, "_flags"}, 64'({o_rden, o_busy, o_done, o_err, o_row_last, o_band_last}), 64'h0);
  endtask

  task automatic build_model(input vec_t v);
    rd_t r;
    expq.delete();
    if (v.exp_err) return;
    for (int rs = 0; rs + v.k <= v.h; rs += v.s)
      for (int ky = 0; ky < v.k; ky++)
        for (int x = 0; x < v.w; x++) begin
          r.addr = v.base + 32'((rs + ky) * v.w + x);
          r.ky   = 3'(ky);
          r.rl   = (x == v.w - 1);
          r.bl   = (x == v.w - 1) && (ky == v.k - 1);
          expq.push_back(r);
        end
  endtask

  task automatic set_cfg(input vec_t v);
    i_conf_base   = v.base;
    i_conf_width  = 8'(v.w);
    i_conf_height = 8'(v.h);
    i_conf_kernel = 3'(v.k);
    i_conf_stride = 2'(v.s);
  endtask

  // Cycle 0 carries i_start; every cycle samples outputs 2 time units after the edge.
  task automatic run_pass(input vec_t v, input int stall_at, input int stall_len,
                          input int abort_at, input int restart_at);
    int  stalled = 0;
    bit  aborted = 0;
    n_reads = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0; err_cnt = 0;
    done_cyc = -1; err_cyc = -1; idle_cyc = -1; last_addr = '0;
    build_model(v);
    set_cfg(v);
    i_start = 1'b1; i_stall = 1'b0; i_abort = 1'b0;
    #1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc < 400; cyc++) begin
      i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
      if (n_reads == stall_at && stalled < stall_len) begin i_stall = 1'b1; stalled++; end
      if (n_reads == abort_at && !aborted && cyc > 1) begin i_abort = 1'b1; aborted = 1; end
      if (cyc == restart_at) begin
        i_start = 1'b1; i_conf_base = 32'hDEAD_0000; i_conf_width = 8'd9;
      end
      #1;
      if (i_abort) chk("abort_rden", 64'(o_rden), 64'h0);
      if (i_stall && n_reads < expq.size()) begin
        chk("stall_rden", 64'(o_rden), 64'h0);
        chk("stall_addr", 64'(o_addr), 64'(expq[n_reads].addr));
      end
      if (o_rden) begin
        if (n_reads < expq.size())
          chk($sformatf("read%0d", n_reads),
              64'({o_addr, o_ky, o_row_last, o_band_last}), 64'(expq[n_reads]));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc  = cyc;
        last_addr = o_addr;
        n_reads++;
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_err)  begin err_cnt++;  err_cyc = cyc;  end
      if (!o_busy) begin idle_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
  endtask

  task automatic check_pass(input vec_t v, input int stall_len, input string tag);
    chk({tag, "_reads"}, 64'(n_reads), 64'(v.exp_reads));
    if (!v.exp_err) begin
      chk({tag, "_last_addr"}, 64'(last_addr), 64'(v.exp_last));
      chk({tag, "_first_cyc"}, 64'(first_cyc), 64'd2);
      chk({tag, "_last_cyc"}, 64'(last_cyc), 64'(1 + v.exp_reads + stall_len));
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(2 + v.exp_reads + stall_len));
      chk({tag, "_idle_cyc"}, 64'(idle_cyc), 64'(3 + v.exp_reads + stall_len));
      chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    end else begin
      chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd1);
      chk({tag, "_err_cyc"}, 64'(err_cyc), 64'd2);
      chk({tag, "_idle_cyc"}, 64'(idle_cyc), 64'd3);
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
    end
    $display("pass %s: reads=%0d last=%0h done=%0d err=%0d idle@%0d",
             tag, n_reads, last_addr, done_cnt, err_cnt, idle_cyc);
  endtask

  initial begin
    int quiet;
    //          w  h  k  s  base           reads last          err
    vecs[0]  = '{4, 4, 3, 1, 32'h0000_0100, 24, 32'h0000_010F, 1'b0};
    vecs[1]  = '{4, 5, 3, 2, 32'h0000_0100, 24, 32'h0000_0113, 1'b0};
    vecs[2]  = '{3, 3, 3, 1, 32'h0000_0200,  9, 32'h0000_0208, 1'b0};
    vecs[3]  = '{4, 4, 5, 1, 32'h0000_0100,  0, 32'h0,         1'b1};
    vecs[4]  = '{0, 4, 3, 1, 32'h0000_0100,  0, 32'h0,         1'b1};
    vecs[5]  = '{4, 4, 3, 0, 32'h0000_0100,  0, 32'h0,         1'b1};
    vecs[6]  = '{4, 4, 0, 1, 32'h0000_0100,  0, 32'h0,         1'b1};
    vecs[7]  = '{1, 3, 1, 3, 32'h0000_0300,  1, 32'h0000_0300, 1'b0};
    vecs[8]  = '{2, 2, 2, 1, 32'hFFFF_FFFE,  4, 32'h0000_0001, 1'b0};
    vecs[9]  = '{2, 7, 2, 3, 32'h0000_0040,  8, 32'h0000_0049, 1'b0};
    vecs[10] = '{2, 7, 7, 1, 32'h0000_0500, 14, 32'h0000_050D, 1'b0};

    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0;
    set_cfg(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_pass(vecs[i], -1, 0, -1, -1);
      check_pass(vecs[i], 0, $sformatf("vec%0d", i));
    end

    run_pass(vecs[0], 5, 3, -1, -1);
    check_pass(vecs[0], 3, "stall");

    run_pass(vecs[0], -1, 0, 6, -1);
    chk("abort_reads", 64'(n_reads), 64'd6);
    chk("abort_done", 64'(done_cnt + err_cnt), 64'd0);
    chk("abort_idle_cyc", 64'(idle_cyc), 64'd9);
    $display("pass abort: reads=%0d idle@%0d", n_reads, idle_cyc);
    run_pass(vecs[0], -1, 0, -1, -1);
    check_pass(vecs[0], 0, "after_abort");

    run_pass(vecs[0], -1, 0, -1, 5);
    check_pass(vecs[0], 0, "restart_ignored");

    set_cfg(vecs[0]);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_busy_before", 64'(o_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("midrst");
    rst = 1'b0;
    quiet = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done || o_busy || o_rden) quiet++;
    end
    chk("midrst_quiet", 64'(quiet), 64'd0);
    $display("pass midrst: stray_cycles=%0d", quiet);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
